// File: rtl/row_clear_sequencer_if.sv
// row_clear_sequencer_if: game-flow and board-datapath handshake for the row clear sequencer
interface row_clear_sequencer_if #(
    parameter int ROWS    = 22,
    parameter int LINES_W = 16,
    parameter int SCORE_W = 24
);
    logic               start;
    logic               new_game;
    logic [ROWS-1:0]    full_rows;
    logic [ROWS-1:0]    shift_row;
    logic               shift_en;
    logic               busy;
    logic               done;
    logic [4:0]         burst;
    logic [LINES_W-1:0] lines_total;
    logic [SCORE_W-1:0] score;
    modport master (
        output start, new_game, full_rows,
        input  shift_row, shift_en, busy, done, burst, lines_total, score
    );
    modport slave (
        input  start, new_game, full_rows,
        output shift_row, shift_en, busy, done, burst, lines_total, score
    );
endinterface

// File: rtl/row_clear_sequencer.sv
// row_clear_sequencer: removes snapshotted full rows bottom-first, paced shifts, keeps line/score totals
module row_clear_sequencer #(
    parameter int ROWS       = 22,
    parameter int STEP_DELAY = 300,
    parameter int LINES_W    = 16,
    parameter int SCORE_W    = 24
) (
    input logic clk,
    input logic reset,
    row_clear_sequencer_if.slave bus
);
    localparam int CW = $clog2(STEP_DELAY + 1);
    typedef enum logic [2:0] {IDLE, SCAN, SHIFT, WAIT, DONE} state_t;
    state_t             state, state_nx;
    logic [ROWS-1:0]    mask;
    logic [ROWS-1:0]    bottom;
    logic [CW-1:0]      cnt;
    logic [4:0]         pass;
    logic [10:0]        pts;
    logic [LINES_W:0]   lines_sum;
    logic [SCORE_W:0]   score_sum;
    logic               shift_en_nx, busy_nx, done_nx;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? SCAN : IDLE;
            SCAN:    state_nx = |mask ? SHIFT : DONE;
            SHIFT:   state_nx = WAIT;
            WAIT:    state_nx = (cnt == CW'(STEP_DELAY - 1)) ? SCAN : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they can be registered without adding latency.
    always_comb begin
        bottom = '0;
        for (int i = 0; i < ROWS; i++)
            if (mask[i]) begin
                bottom    = '0;
                bottom[i] = 1'b1;
            end
        shift_en_nx = state_nx == SHIFT;
        busy_nx     = state_nx != IDLE;
        done_nx     = state_nx == DONE;
        pts = pass == 5'd0 ? 11'd0 : pass == 5'd1 ? 11'd40 : pass == 5'd2 ? 11'd100 :
              pass == 5'd3 ? 11'd300 : 11'd1200;
        lines_sum = {1'b0, bus.lines_total} + (LINES_W + 1)'(pass);
        score_sum = {1'b0, bus.score} + (SCORE_W + 1)'(pts);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask            <= '0;
            cnt             <= '0;
            pass            <= '0;
            bus.shift_row   <= '0;
            bus.shift_en    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.burst       <= '0;
            bus.lines_total <= '0;
            bus.score       <= '0;
        end else begin
            bus.shift_en  <= shift_en_nx;
            bus.shift_row <= shift_en_nx ? bottom : '0;
            bus.busy      <= busy_nx;
            bus.done      <= done_nx;
            cnt           <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (state == IDLE && bus.start) begin
                mask <= bus.full_rows;
                pass <= '0;
            end
            if (state == IDLE && !bus.start && bus.new_game) begin
                bus.lines_total <= '0;
                bus.score       <= '0;
            end
            // Rows above the removed one slide down, so the snapshot shifts toward the bottom too.
            if (state == SHIFT) begin
                mask <= (mask & ~bus.shift_row) << 1;
                pass <= pass + 1'b1;
            end
            if (state == DONE) begin
                bus.burst       <= pass;
                bus.lines_total <= lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
                bus.score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_row_clear_sequencer.sv
// tb_row_clear_sequencer: directed plus random passes checked against a row-list reference model
module tb_row_clear_sequencer;
    localparam int ROWS = 22;
    localparam int D    = 4;
    localparam int LW   = 6;
    localparam int SW   = 13;
    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    int     n_assert = 0;
    int     n_fail   = 0;
    longint m_lines  = 0;
    longint m_score  = 0;
    longint m_burst  = 0;
    int     pts_tab[5] = '{0, 40, 100, 300, 1200};
    logic [ROWS-1:0] rv;

    row_clear_sequencer_if #(.ROWS(ROWS), .LINES_W(LW), .SCORE_W(SW)) bus ();
    row_clear_sequencer #(.ROWS(ROWS), .STEP_DELAY(D), .LINES_W(LW), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_totals();
        chk("burst", 64'(bus.burst), 64'(m_burst));
        chk("lines_total", 64'(bus.lines_total), 64'(m_lines));
        chk("score", 64'(bus.score), 64'(m_score));
    endtask

    // Full rows sorted bottom-first; the k-th removal hits its original row plus the k rows already removed below it.
    task automatic run_pass(input logic [ROWS-1:0] rows, input bit noise, input bit ng_busy, input bit ng_start);
        int tgt[$];
        int n;
        int last;
        int idx;
        logic [ROWS-1:0] exp_row;
        for (int i = ROWS - 1; i >= 0; i--) if (rows[i]) tgt.push_back(i + tgt.size());
        n    = tgt.size();
        last = 2 + n * (D + 2);
        @(negedge clk);
        bus.full_rows = rows;
        bus.start     = 1'b1;
        bus.new_game  = ng_start;
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start    = 1'b0;
                bus.new_game = 1'b0;
            end
            exp_row = '0;
            if (k >= 2 && (k - 2) % (D + 2) == 0) begin
                idx = (k - 2) / (D + 2);
                if (idx < n) exp_row = ROWS'(1) << tgt[idx];
            end
            chk("shift_en", 64'(bus.shift_en), 64'(|exp_row));
            chk("shift_row", 64'(bus.shift_row), 64'(exp_row));
            chk("done", 64'(bus.done), 64'(k == last));
            chk("busy", 64'(bus.busy), 64'(k <= last));
            if (noise) bus.full_rows = ROWS'($urandom);
            if (ng_busy && n > 0) begin
                bus.start    = (k == 3);
                bus.new_game = (k == 3);
            end
        end
        m_burst = n;
        m_lines = (m_lines + n > (1 << LW) - 1) ? (1 << LW) - 1 : m_lines + n;
        m_score = (m_score + pts_tab[n > 4 ? 4 : n] > (1 << SW) - 1) ? (1 << SW) - 1
                : m_score + pts_tab[n > 4 ? 4 : n];
        chk_idle_totals();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.new_game  = 1'b0;
        bus.full_rows = '0;
        #2;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_shift_en", 64'(bus.shift_en), 64'd0);
        chk("rst_shift_row", 64'(bus.shift_row), 64'd0);
        chk_idle_totals();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_pass(22'h000000, 1'b0, 1'b0, 1'b0);
        run_pass(22'h200000, 1'b0, 1'b0, 1'b0);
        run_pass(22'h3C0000, 1'b0, 1'b0, 1'b0);
        run_pass(22'h280000, 1'b1, 1'b0, 1'b0);
        run_pass(22'h0A5000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        m_lines = 0;
        m_score = 0;
        @(negedge clk);
        chk("ng_lines", 64'(bus.lines_total), 64'd0);
        chk("ng_score", 64'(bus.score), 64'd0);
        run_pass(22'h300001, 1'b0, 1'b0, 1'b0);
        run_pass(22'h000410, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.full_rows = 22'h208400;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        m_lines = 0;
        m_score = 0;
        m_burst = 0;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_shift_en", 64'(bus.shift_en), 64'd0);
        chk("arst_shift_row", 64'(bus.shift_row), 64'd0);
        chk_idle_totals();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3 * (D + 2) + 6; c++) begin
            @(negedge clk);
            chk("post_rst_shift_en", 64'(bus.shift_en), 64'd0);
            chk("post_rst_done", 64'(bus.done), 64'd0);
            chk("post_rst_busy", 64'(bus.busy), 64'd0);
        end
        for (int p = 0; p < 12; p++) begin
            rv = ($urandom_range(0, 3) == 0) ? '0 : ROWS'($urandom);
            if (p == 5) rv = '1;
            run_pass(rv, 1'($urandom), 1'b0, 1'b0);
        end
        for (int p = 0; p < 7; p++) run_pass(22'h00000F, 1'b0, 1'b0, 1'b0);
        chk("lines_sat", 64'(bus.lines_total), 64'(6'h3F));
        chk("score_sat", 64'(bus.score), 64'(13'h1FFF));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/row_clear_sequencer.md
Name: row_clear_sequencer

Overview:
Sequences removal of completed playfield rows after a piece is written into the board. On a start pulse from the game-flow FSM, it snapshots the full-row mask. It then issues one single-row shift-down command per cleared row, bottom-most first, paced by a settle delay. It also keeps the running line and score totals that the display path shows.

Parameters:
ROWS, 22, playfield rows; row 0 = top, row ROWS-1 = bottom
STEP_DELAY, 300, cycles to wait after each shift command before the next scan (min 1)
LINES_W, 16, width of lines_total counter
SCORE_W, 24, width of score counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request from game FSM (check state); ignored unless idle
new_game  in  1  synchronous clear of lines_total/score; ignored unless idle
full_rows  in  ROWS  per-row "row completely filled" flags from board datapath
shift_row  out  ROWS  one-hot row to delete; rows above move down one; zero when not shifting
shift_en  out  1  one-cycle strobe qualifying shift_row
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse when pass finishes (also for zero-row pass)
burst  out  5  rows cleared in the last completed pass, held until next pass done
lines_total  out  LINES_W  cumulative cleared rows, saturating
score  out  SCORE_W  cumulative score, saturating

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; mask, step counter, burst, lines_total, score = 0; shift_row=0; shift_en=0; busy=0; done=0. Reset mid-pass aborts immediately; no further shift_en.
- States: IDLE, SCAN, SHIFT, WAIT, DONE.
- IDLE:
  - start=1: mask <= full_rows, pass count <= 0, go to SCAN.
  - else if new_game=1: lines_total <= 0 and score <= 0.
  - start and new_game in the same cycle: start wins; new_game is dropped.
- SCAN (1 cycle):
  - mask==0: go to DONE.
  - else r = highest set index of mask (bottom-most full row), latch r, go to SHIFT.
- SHIFT (1 cycle):
  - shift_en=1, shift_row=1<<r.
  - mask <= (mask & ~(1<<r)) << 1, truncated to ROWS bits. Remaining full rows all lie above r and each moves down one.
  - pass count += 1; go to WAIT.
- WAIT: count STEP_DELAY cycles, then go to SCAN. full_rows is not re-sampled during a pass; only the snapshot mask is used.
- DONE (1 cycle):
  - done=1; burst <= pass count.
  - lines_total += pass count, saturating at all-ones.
  - score += table(pass count), saturating at all-ones. Table: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - Go to IDLE.
- busy=1 in SCAN, SHIFT, WAIT, DONE.
- Latency:
  - Zero-row pass: start accepted at cycle 0, done at cycle 2.
  - N-row pass: shift_en at cycles 2, 2+(STEP_DELAY+2), …; done at cycle 2+N·(STEP_DELAY+2).
- start or new_game while busy: ignored, with no effect on the current pass.
- All outputs are registered; shift_row is 0 whenever shift_en=0.

Test Plan:
1. Reset released, start with full_rows=0 → done pulses 2 cycles after start, no shift_en, burst=0, score=0, lines_total=0.
2. full_rows bit 21 only, STEP_DELAY=4 → one shift_en with shift_row=1<<21; done follows; burst=1, lines_total=1, score=40.
3. full_rows bits {21,20,19,18} → four shift_en, each shift_row=1<<21 (every remaining row slides into row 21), spaced 6 cycles apart; burst=4, score=1200.
4. full_rows bits {21,19} → shift_row 1<<21, then 1<<20; burst=2, score=100. full_rows toggled during the pass has no effect on the shifts issued.
5. start asserted again while busy, plus new_game while busy → ignored. Later, new_game while idle → lines_total=0, score=0; start together with new_game → pass runs and totals are kept.
6. reset=0 during WAIT of a 3-row pass → all outputs 0 in the same cycle. After release, no shift_en or done until a new start; score preset near max saturates at all-ones.
